// File: rtl/reg_bank_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_bank_rd_arbiter_if
//   Bundles every bus signal of the register-bank read arbiter:
//   the requester side (req / req_op1 / req_op2 / gnt), the response
//   handshake (rsp_*) and the register-bank read port (rf_op* / rf_op*_data).
//
//   Handshake semantics: a response transfers on a rising clock edge where
//   rsp_valid and rsp_ready are both high. Once rsp_valid rises, rsp_valid,
//   rsp_id and rsp_op* stay constant until that transfer. rsp_ready while
//   rsp_valid is low has no effect. A requester holds req high until it sees
//   its one-cycle gnt pulse.
//
//   Modports:
//     master - the arbiter itself (drives gnt, rsp_*, rf_op1/rf_op2)
//     slave  - the surroundings (requesters, consumer, register bank)
// -----------------------------------------------------------------------------
interface reg_bank_rd_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) ();
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_op1;
    logic [NREQ*ADDR_W-1:0] req_op2;
    logic [NREQ-1:0]        gnt;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_op1;
    logic [DATA_W-1:0]      rsp_op2;
    logic [ADDR_W-1:0]      rf_op1;
    logic [ADDR_W-1:0]      rf_op2;
    logic [DATA_W-1:0]      rf_op1_data;
    logic [DATA_W-1:0]      rf_op2_data;

    modport master (
        input  req, req_op1, req_op2, rsp_ready, rf_op1_data, rf_op2_data,
        output gnt, rsp_valid, rsp_id, rsp_op1, rsp_op2, rf_op1, rf_op2
    );

    modport slave (
        output req, req_op1, req_op2, rsp_ready, rf_op1_data, rf_op2_data,
        input  gnt, rsp_valid, rsp_id, rsp_op1, rsp_op2, rf_op1, rf_op2
    );
endinterface

// File: rtl/reg_bank_rd_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_rd_arbiter
//   Shares the two register-bank read ports (op1/op2) between NREQ requesters.
//   A round-robin arbiter grants one requester per transaction, drives both
//   read addresses, waits RF_LAT cycles, captures both operands and returns
//   them on a valid/ready response.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   rb_if        reg_bank_rd_arbiter_if.master (requests, grants, response,
//                register-bank read port)
//   busy         high whenever the FSM is not in IDLE
//   o_dbg_state  current FSM state (0 IDLE, 1 READ, 2 RESP)
// -----------------------------------------------------------------------------
module reg_bank_rd_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RF_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    reg_bank_rd_arbiter_if.master         rb_if,
    output logic                          busy,
    output logic [1:0]                    o_dbg_state
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int LAT_W = $clog2(RF_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_op1;
    logic [DATA_W-1:0]   r_rsp_op2;
    logic [ADDR_W-1:0]   r_rf_op1;
    logic [ADDR_W-1:0]   r_rf_op2;

    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W:0]       w_scan;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ADDR_W-1:0]   w_pick_op1;
    logic [ADDR_W-1:0]   w_pick_op2;
    logic                w_accept;
    logic                w_sample;

    // Round-robin scan: first set req bit at or above r_rr_ptr, wrapping.
    // w_scan is one bit wider so rr_ptr + i cannot overflow before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_scan >= (ID_W+1)'(NREQ)) begin
                w_scan = w_scan - (ID_W+1)'(NREQ);
            end
            if (!w_found && rb_if.req[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_pick == ID_W'(NREQ - 1)) ? '0 : w_pick + ID_W'(1);

    // Address mux for the winning requester.
    always_comb begin
        w_pick_op1 = '0;
        w_pick_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == ID_W'(i)) begin
                w_pick_op1 = rb_if.req_op1[i*ADDR_W +: ADDR_W];
                w_pick_op2 = rb_if.req_op2[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                // lat_cnt == 1 marks the last READ cycle: data is valid now.
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rb_if.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_lat_cnt   <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_op1   <= '0;
            r_rsp_op2   <= '0;
            r_rf_op1    <= '0;
            r_rf_op2    <= '0;
        end else begin
            if (w_accept) begin
                r_rf_op1  <= w_pick_op1;
                r_rf_op2  <= w_pick_op2;
                r_rsp_id  <= w_pick;
                r_rr_ptr  <= w_ptr_nxt;
                r_lat_cnt <= LAT_W'(RF_LAT);
            end
            if (r_state == S_READ) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_sample) begin
                r_rsp_op1   <= rb_if.rf_op1_data;
                r_rsp_op2   <= rb_if.rf_op2_data;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == S_RESP) && rb_if.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // gnt is combinational so it pulses in the accepting cycle itself; the
    // rst_n gate keeps it quiet while reset is held with requests pending.
    always_comb begin
        rb_if.gnt = '0;
        if (w_accept && rst_n) begin
            rb_if.gnt[w_pick] = 1'b1;
        end
    end

    assign rb_if.rsp_valid = r_rsp_valid;
    assign rb_if.rsp_id    = r_rsp_id;
    assign rb_if.rsp_op1   = r_rsp_op1;
    assign rb_if.rsp_op2   = r_rsp_op2;
    assign rb_if.rf_op1    = r_rf_op1;
    assign rb_if.rf_op2    = r_rf_op2;
    assign busy            = (r_state != S_IDLE);
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_reg_bank_rd_arbiter.sv
module tb_reg_bank_rd_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int ID_W   = 1;
    localparam int EXP_W  = ID_W + 2*DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy1, busy3;
    logic [1:0] st1, st3;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] rf_mem [16];
    logic [EXP_W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    reg_bank_rd_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    reg_bank_rd_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

    reg_bank_rd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RF_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rb_if(bus1), .busy(busy1), .o_dbg_state(st1)
    );
    reg_bank_rd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RF_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rb_if(bus3), .busy(busy3), .o_dbg_state(st3)
    );

    // Register bank model for the RF_LAT=1 instance: data follows the address.
    assign bus1.rf_op1_data = rf_mem[bus1.rf_op1];
    assign bus1.rf_op2_data = rf_mem[bus1.rf_op2];

    // ---------------- clock / reset helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus1.req = '0;
        bus3.req = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference round-robin: first requesting index at or after ptr, wrapping.
    function automatic int ref_pick(logic [NREQ-1:0] r, int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus1.req = 2'b11;
        bus3.req = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({bus1.gnt, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2,
                 bus1.rf_op1, bus1.rf_op2, busy1, st1} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs_dut1: got gnt=%b v=%b id=%h op1=%h op2=%h rf1=%h rf2=%h busy=%b st=%0d expected all zero",
                         bus1.gnt, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2,
                         bus1.rf_op1, bus1.rf_op2, busy1, st1);
            end
            n_checks++;
            if ({bus3.gnt, bus3.rsp_valid, bus3.rsp_id, bus3.rsp_op1, bus3.rsp_op2,
                 bus3.rf_op1, bus3.rf_op2, busy3} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs_dut3: got gnt=%b v=%b id=%h op1=%h op2=%h rf1=%h rf2=%h busy=%b expected all zero",
                         bus3.gnt, bus3.rsp_valid, bus3.rsp_id, bus3.rsp_op1, bus3.rsp_op2,
                         bus3.rf_op1, bus3.rf_op2, busy3);
            end
        end
        bus1.req = '0;
        bus3.req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rf_mem[0] = 16'h0008;
        rf_mem[1] = 16'h0038;
        bus1.req       = 2'b01;
        bus1.req_op1   = 8'h50;   // requester 0 op1 = 0
        bus1.req_op2   = 8'h61;   // requester 0 op2 = 1
        bus1.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus1.gnt !== 2'b01) begin
            n_errors++; $display("FAIL single_gnt: got %b expected 01", bus1.gnt);
        end
        tick();
        bus1.req = '0;
        #1;
        n_checks++;
        if ({bus1.gnt, bus1.rsp_valid, busy1, bus1.rf_op1, bus1.rf_op2} !== {2'b00, 1'b0, 1'b1, 4'h0, 4'h1}) begin
            n_errors++;
            $display("FAIL single_read_phase: got gnt=%b v=%b busy=%b rf1=%h rf2=%h expected 00 0 1 0 1",
                     bus1.gnt, bus1.rsp_valid, busy1, bus1.rf_op1, bus1.rf_op2);
        end
        tick();
        n_checks++;
        if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2} !== {1'b1, 1'b0, 16'h0008, 16'h0038}) begin
            n_errors++;
            $display("FAIL single_rsp: got v=%b id=%h op1=%h op2=%h expected 1 0 0008 0038",
                     bus1.rsp_valid, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2);
        end
        tick();
        n_checks++;
        if ({bus1.rsp_valid, busy1, bus1.rf_op1, bus1.rf_op2} !== {1'b0, 1'b0, 4'h0, 4'h1}) begin
            n_errors++;
            $display("FAIL single_done: got v=%b busy=%b rf1=%h rf2=%h expected 0 0 0 1",
                     bus1.rsp_valid, busy1, bus1.rf_op1, bus1.rf_op2);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_gnt;
        int exp_ids [4] = '{0, 1, 0, 1};
        do_reset();
        bus1.req       = 2'b11;
        bus1.req_op1   = 8'($urandom);
        bus1.req_op2   = 8'($urandom);
        bus1.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = '0;
            exp_gnt[exp_ids[k]] = 1'b1;
            #1;
            n_checks++;
            if (bus1.gnt !== exp_gnt) begin
                n_errors++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, bus1.gnt, exp_gnt);
            end
            tick();
            n_checks++;
            if ({bus1.gnt, busy1} !== {2'b00, 1'b1}) begin
                n_errors++; $display("FAIL rr_spacing_%0d: got gnt=%b busy=%b expected 00 1", k, bus1.gnt, busy1);
            end
            tick();
            n_checks++;
            if ({bus1.gnt, bus1.rsp_valid, bus1.rsp_id} !== {2'b00, 1'b1, ID_W'(exp_ids[k])}) begin
                n_errors++;
                $display("FAIL rr_rsp_%0d: got gnt=%b v=%b id=%0d expected 00 1 %0d",
                         k, bus1.gnt, bus1.rsp_valid, bus1.rsp_id, exp_ids[k]);
            end
            tick();
        end
        bus1.req = '0;
    endtask

    task automatic test_backpressure();
        logic [EXP_W-1:0] exp0;
        logic [EXP_W-1:0] exp1;
        logic [ADDR_W-1:0] a1, a2;
        do_reset();
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
        bus1.req       = 2'b11;
        bus1.req_op1   = 8'($urandom);
        bus1.req_op2   = 8'($urandom);
        bus1.rsp_ready = 1'b0;
        a1 = bus1.req_op1[3:0];
        a2 = bus1.req_op2[3:0];
        exp0 = {1'b0, rf_mem[a1], rf_mem[a2]};
        #1;
        n_checks++;
        if (bus1.gnt !== 2'b01) begin
            n_errors++; $display("FAIL bp_gnt0: got %b expected 01", bus1.gnt);
        end
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            bus1.req_op1 = 8'($urandom);   // must not disturb the held transaction
            bus1.req_op2 = 8'($urandom);
            #1;
            n_checks++;
            if ({bus1.rsp_valid, bus1.gnt, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2, bus1.rf_op1, bus1.rf_op2}
                !== {1'b1, 2'b00, exp0, a1, a2}) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: got v=%b gnt=%b rsp=%h rf1=%h rf2=%h expected 1 00 %h %h %h",
                         c, bus1.rsp_valid, bus1.gnt, {bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2},
                         bus1.rf_op1, bus1.rf_op2, exp0, a1, a2);
            end
            tick();
        end
        bus1.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus1.rsp_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_ready_cycle_valid: got %b expected 1", bus1.rsp_valid);
        end
        tick();
        exp1 = {1'b1, rf_mem[bus1.req_op1[7:4]], rf_mem[bus1.req_op2[7:4]]};
        #1;
        n_checks++;
        if ({bus1.rsp_valid, busy1, bus1.gnt} !== {1'b0, 1'b0, 2'b10}) begin
            n_errors++;
            $display("FAIL bp_regrant: got v=%b busy=%b gnt=%b expected 0 0 10", bus1.rsp_valid, busy1, bus1.gnt);
        end
        tick();
        bus1.req = '0;
        tick();
        n_checks++;
        if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2} !== {1'b1, exp1}) begin
            n_errors++;
            $display("FAIL bp_second_rsp: got v=%b rsp=%h expected 1 %h",
                     bus1.rsp_valid, {bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2}, exp1);
        end
        tick();
    endtask

    task automatic test_latency3();
        logic [DATA_W-1:0] junk1 [3] = '{16'h1111, 16'h3333, 16'hC0DE};
        logic [DATA_W-1:0] junk2 [3] = '{16'h2222, 16'h4444, 16'hBEEF};
        do_reset();
        bus3.req         = 2'b10;
        bus3.req_op1     = 8'h73;   // requester 1 op1 = 7
        bus3.req_op2     = 8'h92;   // requester 1 op2 = 9
        bus3.rsp_ready   = 1'b0;
        bus3.rf_op1_data = 16'h0000;
        bus3.rf_op2_data = 16'h0000;
        #1;
        n_checks++;
        if (bus3.gnt !== 2'b10) begin
            n_errors++; $display("FAIL lat3_gnt: got %b expected 10", bus3.gnt);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            bus3.req = '0;
            bus3.rf_op1_data = junk1[c];   // only the last value (cycle 3) counts
            bus3.rf_op2_data = junk2[c];
            #1;
            n_checks++;
            if ({bus3.rf_op1, bus3.rf_op2, bus3.rsp_valid, busy3} !== {4'h7, 4'h9, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL lat3_read_%0d: got rf1=%h rf2=%h v=%b busy=%b expected 7 9 0 1",
                         c, bus3.rf_op1, bus3.rf_op2, bus3.rsp_valid, busy3);
            end
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            bus3.rf_op1_data = 16'hDEAD;
            bus3.rf_op2_data = 16'hDEAD;
            #1;
            n_checks++;
            if ({bus3.rsp_valid, bus3.rsp_id, bus3.rsp_op1, bus3.rsp_op2} !== {1'b1, 1'b1, 16'hC0DE, 16'hBEEF}) begin
                n_errors++;
                $display("FAIL lat3_rsp_%0d: got v=%b id=%h op1=%h op2=%h expected 1 1 c0de beef",
                         c, bus3.rsp_valid, bus3.rsp_id, bus3.rsp_op1, bus3.rsp_op2);
            end
        end
        bus3.rsp_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus3.rsp_valid, busy3, bus3.rf_op1, bus3.rf_op2} !== {1'b0, 1'b0, 4'h7, 4'h9}) begin
            n_errors++;
            $display("FAIL lat3_done: got v=%b busy=%b rf1=%h rf2=%h expected 0 0 7 9",
                     bus3.rsp_valid, busy3, bus3.rf_op1, bus3.rf_op2);
        end
        bus3.rsp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus1.req       = 2'b11;
        bus1.req_op1   = 8'h35;
        bus1.req_op2   = 8'h46;
        bus1.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus1.gnt !== 2'b01) begin
            n_errors++; $display("FAIL mr_gnt: got %b expected 01", bus1.gnt);
        end
        tick();
        rst_n = 1'b0;   // lands while the transaction is in READ
        tick();
        n_checks++;
        if ({bus1.gnt, bus1.rsp_valid, busy1, bus1.rsp_op1, bus1.rsp_op2, bus1.rf_op1, bus1.rf_op2} !== '0) begin
            n_errors++;
            $display("FAIL mr_cleared: got gnt=%b v=%b busy=%b op1=%h op2=%h rf1=%h rf2=%h expected all zero",
                     bus1.gnt, bus1.rsp_valid, busy1, bus1.rsp_op1, bus1.rsp_op2, bus1.rf_op1, bus1.rf_op2);
        end
        rst_n = 1'b1;
        bus1.req = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({bus1.rsp_valid, bus1.gnt, busy1} !== 4'b0) begin
                n_errors++;
                $display("FAIL mr_no_stale_%0d: got v=%b gnt=%b busy=%b expected 0 00 0", c, bus1.rsp_valid, bus1.gnt, busy1);
            end
        end
        bus1.req = 2'b11;   // pointer back at 0 -> requester 0 wins again
        #1;
        n_checks++;
        if (bus1.gnt !== 2'b01) begin
            n_errors++; $display("FAIL mr_ptr_cleared: got %b expected 01", bus1.gnt);
        end
        tick();
        bus1.req = '0;
        tick();
        tick();
    endtask

    // Randomised traffic against a transaction/time-based model.
    task automatic test_random();
        int m_ptr, k, c;
        bit outstanding;
        int valid_at;
        logic exp_valid, exp_busy;
        logic [NREQ-1:0] exp_gnt;
        logic [ADDR_W-1:0] a1, a2;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
        m_ptr = 0; outstanding = 0; valid_at = 0;
        for (c = 0; c < 400; c++) begin
            bus1.req       = NREQ'($urandom_range(0, 3));
            bus1.req_op1   = 8'($urandom);
            bus1.req_op2   = 8'($urandom);
            bus1.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_busy  = outstanding;
            exp_valid = outstanding && (c >= valid_at);
            exp_gnt   = '0;
            k = -1;
            if (!outstanding && (bus1.req != '0)) begin
                k = ref_pick(bus1.req, m_ptr);
                exp_gnt[k] = 1'b1;
            end
            n_checks++;
            if ({bus1.gnt, bus1.rsp_valid, busy1} !== {exp_gnt, exp_valid, exp_busy}) begin
                n_errors++;
                $display("FAIL rand_ctrl_c%0d: got gnt=%b v=%b busy=%b expected %b %b %b",
                         c, bus1.gnt, bus1.rsp_valid, busy1, exp_gnt, exp_valid, exp_busy);
            end
            if (exp_valid && exp_q.size() > 0) begin
                n_checks++;
                if ({bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2} !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL rand_data_c%0d: got %h expected %h",
                             c, {bus1.rsp_id, bus1.rsp_op1, bus1.rsp_op2}, exp_q[0]);
                end
            end
            if (exp_valid && bus1.rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                outstanding = 0;
            end
            if (k >= 0) begin
                a1 = bus1.req_op1[k*ADDR_W +: ADDR_W];
                a2 = bus1.req_op2[k*ADDR_W +: ADDR_W];
                exp_q.push_back({ID_W'(k), rf_mem[a1], rf_mem[a2]});
                outstanding = 1;
                valid_at = c + 2;   // RF_LAT + 1
                m_ptr = (k + 1) % NREQ;
            end
            tick();
        end
        bus1.req = '0;
        bus1.rsp_ready = 1'b1;
        tick();
        tick();
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        bus1.req = '0; bus1.req_op1 = '0; bus1.req_op2 = '0; bus1.rsp_ready = 1'b0;
        bus3.req = '0; bus3.req_op1 = '0; bus3.req_op2 = '0; bus3.rsp_ready = 1'b0;
        bus3.rf_op1_data = '0; bus3.rf_op2_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_latency3();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
